// File: rtl/pacman_pkg.sv
// Shared pacman constants and types: movement direction codes, wall-vector bit layout,
// default maze geometry and the wall-query arbiter state encoding.
package pacman_pkg;

  localparam logic [2:0] STOP  = 3'b000;
  localparam logic [2:0] UP    = 3'b100;
  localparam logic [2:0] RIGHT = 3'b101;
  localparam logic [2:0] DOWN  = 3'b110;
  localparam logic [2:0] LEFT  = 3'b111;

  // Bit positions inside adjacent_walls; also the order in which neighbours are probed.
  localparam logic [1:0] WALL_UP    = 2'd0;
  localparam logic [1:0] WALL_RIGHT = 2'd1;
  localparam logic [1:0] WALL_DOWN  = 2'd2;
  localparam logic [1:0] WALL_LEFT  = 2'd3;

  localparam int         MAP_W_DEF     = 40;
  localparam int         MAP_H_DEF     = 30;
  localparam logic [1:0] WALL_CODE_DEF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping,
// returned both as a one-hot grant and as an index.
module rr_priority_picker #(
  parameter int  N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic found;
    int   j;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/wall_query_arbiter.sv
// Shares the maze ROM read port between pacman and the ghosts: probes the four neighbours of
// the granted requester's tile one slot at a time and returns a one-cycle ack plus wall vector.
module wall_query_arbiter
  import pacman_pkg::*;
#(
  parameter int                N_REQ     = 5,
  parameter int                MAP_W     = MAP_W_DEF,
  parameter int                MAP_H     = MAP_H_DEF,
  parameter int                ROM_LAT   = 1,
  parameter int                TILE_W    = 2,
  parameter logic [TILE_W-1:0] WALL_CODE = TILE_W'(WALL_CODE_DEF),
  localparam int               ADDR_W    = $clog2(MAP_W * MAP_H)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [6*N_REQ-1:0]   tile_x_flat,
  input  logic [6*N_REQ-1:0]   tile_y_flat,
  output logic [N_REQ-1:0]     ack,
  output logic [3:0]           walls_out,
  output logic                 rom_rd,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [TILE_W-1:0]    rom_data
);

  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int               CNT_W    = $clog2(ROM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LAT);

  arb_state_t        state_q;
  logic [IDX_W-1:0]  ptr_q, idx_q;
  logic [N_REQ-1:0]  gnt_q, ack_q;
  logic [5:0]        x_q, y_q;
  logic [1:0]        slot_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [3:0]        walls_acc_q, walls_out_q;
  logic              rom_rd_q;
  logic [ADDR_W-1:0] rom_addr_q;

  logic [5:0]        req_x [N_REQ];
  logic [5:0]        req_y [N_REQ];
  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [1:0]        slot_d;
  logic [5:0]        nb_x_d, nb_y_d;
  logic              nb_edge_d, cur_wall_d;
  logic [ADDR_W-1:0] nb_addr_d;
  logic [3:0]        walls_acc_d;

  function automatic logic is_edge(input logic [5:0] x, input logic [5:0] y, input logic [1:0] s);
    logic r;
    case (s)
      WALL_UP:    r = (y == 6'd0);
      WALL_RIGHT: r = (x == 6'(MAP_W - 1));
      WALL_DOWN:  r = (y == 6'(MAP_H - 1));
      default:    r = (x == 6'd0);
    endcase
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] neighbour_addr(input logic [5:0] x, input logic [5:0] y,
                                                       input logic [1:0] s);
    logic [ADDR_W-1:0] nx, ny;
    nx = ADDR_W'(x);
    ny = ADDR_W'(y);
    case (s)
      WALL_UP:    ny = ny - 1'b1;
      WALL_RIGHT: nx = nx + 1'b1;
      WALL_DOWN:  ny = ny + 1'b1;
      default:    nx = nx - 1'b1;
    endcase
    return ny * ADDR_W'(MAP_W) + nx;
  endfunction

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_x[gi] = tile_x_flat[6*gi +: 6];
      assign req_y[gi] = tile_y_flat[6*gi +: 6];
    end
  endgenerate

  rr_priority_picker #(.N(N_REQ)) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Neighbour to probe next: the granted tile's up-neighbour when leaving IDLE, else the next slot.
  always_comb begin
    slot_d = slot_q + 2'd1;
    nb_x_d = x_q;
    nb_y_d = y_q;
    if (state_q == ST_IDLE) begin
      slot_d = WALL_UP;
      nb_x_d = req_x[pick_idx];
      nb_y_d = req_y[pick_idx];
    end
    walls_acc_d         = walls_acc_q;
    walls_acc_d[slot_q] = cur_wall_d;
  end

  assign nb_edge_d  = is_edge(nb_x_d, nb_y_d, slot_d);
  assign nb_addr_d  = neighbour_addr(nb_x_d, nb_y_d, slot_d);
  assign cur_wall_d = is_edge(x_q, y_q, slot_q) || (rom_data == WALL_CODE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      slot_q      <= '0;
      cyc_q       <= '0;
      walls_acc_q <= '0;
      walls_out_q <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      ack_q    <= '0;
      rom_rd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            idx_q   <= pick_idx;
            gnt_q   <= pick_grant;
            x_q     <= nb_x_d;
            y_q     <= nb_y_d;
            slot_q  <= WALL_UP;
            cyc_q   <= '0;
            rom_rd_q <= !nb_edge_d;
            if (!nb_edge_d) rom_addr_q <= nb_addr_d;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (cyc_q == CNT_LAST) begin
            walls_acc_q <= walls_acc_d;
            if (slot_q == WALL_LEFT) begin
              ack_q       <= gnt_q;
              walls_out_q <= walls_acc_d;
              state_q     <= ST_RESP;
            end else begin
              slot_q   <= slot_d;
              cyc_q    <= '0;
              rom_rd_q <= !nb_edge_d;
              if (!nb_edge_d) rom_addr_q <= nb_addr_d;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_RESP: begin
          ptr_q   <= (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign walls_out = walls_out_q;
  assign rom_rd    = rom_rd_q;
  assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_wall_query_arbiter.sv
// Bench for wall_query_arbiter: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a transaction-schedule model.
module tb_wall_query_arbiter;

  parameter int  ROM_LAT = 1;
  localparam int N_REQ   = 5;
  localparam int MAP_W   = 40;
  localparam int MAP_H   = 30;
  localparam int ADDR_W  = $clog2(MAP_W * MAP_H);
  localparam int SLOT    = ROM_LAT + 1;
  localparam int LAT     = 1 + 4 * SLOT;
  localparam int PERIOD  = 2 + 4 * SLOT;
  localparam logic [1:0] WALL = 2'b01;

  logic                Clk = 1'b0;
  logic                Reset = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [6*N_REQ-1:0]  tile_x_flat = '0;
  logic [6*N_REQ-1:0]  tile_y_flat = '0;
  logic [N_REQ-1:0]    ack;
  logic [3:0]          walls_out;
  logic                rom_rd;
  logic [ADDR_W-1:0]   rom_addr;
  logic [1:0]          rom_data;

  logic [1:0] rom_mem  [MAP_W*MAP_H];
  logic [1:0] rom_pipe [ROM_LAT];

  int tests = 0;
  int fails = 0;
  int n = 0;
  bit auto_drop = 1'b0;
  logic [N_REQ-1:0] ack_prev = '0;
  int rd_count = 0, rd_last = 0, rd_gap = 0;
  int ack_idx_log[$];
  int ack_cyc_log[$];

  wall_query_arbiter #(
    .N_REQ(N_REQ), .MAP_W(MAP_W), .MAP_H(MAP_H), .ROM_LAT(ROM_LAT), .TILE_W(2), .WALL_CODE(WALL)
  ) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .tile_x_flat(tile_x_flat), .tile_y_flat(tile_y_flat),
    .ack(ack), .walls_out(walls_out), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 Clk = ~Clk;

  // ROM with ROM_LAT cycles of latency; junk on the bus whenever no read was issued.
  always @(posedge Clk) begin
    rom_pipe[0] <= (rom_rd && rom_addr < ADDR_W'(MAP_W * MAP_H)) ? rom_mem[rom_addr] : 2'($urandom);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  function automatic bit on_edge(input int x, input int y, input int s);
    case (s)
      0:       return y == 0;
      1:       return x == MAP_W - 1;
      2:       return y == MAP_H - 1;
      default: return x == 0;
    endcase
  endfunction

  function automatic int nb_addr(input int x, input int y, input int s);
    int nx, ny;
    nx = x;
    ny = y;
    case (s)
      0:       ny = y - 1;
      1:       nx = x + 1;
      2:       ny = y + 1;
      default: nx = x - 1;
    endcase
    return ny * MAP_W + nx;
  endfunction

  // Model: a grant at cycle g implies reads at g+1+s*SLOT for in-range slots and an ack at g+LAT.
  bit         m_busy = 1'b0;
  int         m_g, m_idx, m_x, m_y, m_ptr = 0;
  logic [3:0] m_new, m_walls = '0;

  initial begin
    int               off, j;
    logic             e_rd;
    int               e_addr;
    logic [N_REQ-1:0] e_ack;
    logic [3:0]       e_walls;
    forever begin
      @(negedge Clk);
      n++;
      e_rd = 1'b0; e_addr = 0; e_ack = '0; e_walls = m_walls;
      if (Reset) begin
        m_busy = 1'b0; m_ptr = 0; m_walls = '0; e_walls = '0;
        check("rst_addr", int'(rom_addr), 0);
      end else if (m_busy) begin
        off = n - m_g;
        if (off >= 1 && off <= 4 * SLOT && (off - 1) % SLOT == 0 &&
            !on_edge(m_x, m_y, (off - 1) / SLOT)) begin
          e_rd   = 1'b1;
          e_addr = nb_addr(m_x, m_y, (off - 1) / SLOT);
        end
        if (off == LAT) begin
          e_ack[m_idx] = 1'b1;
          m_walls = m_new;
          e_walls = m_new;
          m_busy  = 1'b0;
          m_ptr   = (m_idx + 1) % N_REQ;
        end
      end else if (req != '0) begin
        for (int k = 0; k < N_REQ; k++) begin
          j = (m_ptr + k) % N_REQ;
          if (!m_busy && req[j]) begin
            m_busy = 1'b1; m_idx = j; m_g = n;
            m_x = int'(tile_x_flat[6*j +: 6]);
            m_y = int'(tile_y_flat[6*j +: 6]);
          end
        end
        for (int s = 0; s < 4; s++)
          m_new[s] = on_edge(m_x, m_y, s) ? 1'b1 : (rom_mem[nb_addr(m_x, m_y, s)] == WALL);
      end
      check("ack", int'(ack), int'(e_ack));
      check("walls_out", int'(walls_out), int'(e_walls));
      check("rom_rd", int'(rom_rd), int'(e_rd));
      if (e_rd) check("rom_addr", int'(rom_addr), e_addr);
      ack_prev = ack;
      if (rom_rd) begin
        rd_count++;
        rd_gap  = n - rd_last;
        rd_last = n;
      end
      for (int i = 0; i < N_REQ; i++)
        if (ack[i]) begin
          ack_idx_log.push_back(i);
          ack_cyc_log.push_back(n);
          $display("[TB] cycle %0d ack req%0d walls_out=%b", n, i, walls_out);
        end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    if (auto_drop) req = req & ~ack_prev;
  endtask

  task automatic set_xy(input int i, input int x, input int y);
    tile_x_flat[6*i +: 6] = 6'(x);
    tile_y_flat[6*i +: 6] = 6'(y);
  endtask

  task automatic clear_log();
    ack_idx_log.delete();
    ack_cyc_log.delete();
  endtask

  task automatic wait_acks(input int cnt, input int budget);
    int k;
    k = 0;
    while (ack_idx_log.size() < cnt && k < budget) begin
      tick();
      k++;
    end
    if (ack_idx_log.size() < cnt) check("ack_timeout", ack_idx_log.size(), cnt);
  endtask

  task automatic run_single(input string tag, input int idx, input int x, input int y,
                            input int ew, input int erd, input bit jitter);
    int g, rd0;
    clear_log();
    rd0 = rd_count;
    set_xy(idx, x, y);
    req[idx] = 1'b1;
    g = n + 1;
    if (jitter) begin
      tick();
      set_xy(idx, 20, 20);
    end
    wait_acks(1, LAT + 10);
    if (ack_idx_log.size() > 0) begin
      check({tag, "_latency"}, ack_cyc_log[0] - g, LAT);
      check({tag, "_idx"}, ack_idx_log[0], idx);
    end
    check({tag, "_walls"}, int'(walls_out), ew);
    check({tag, "_rd_count"}, rd_count - rd0, erd);
    check({tag, "_rd_gap"}, rd_gap, SLOT);
  endtask

  function automatic int rand_coord(input int lim);
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return lim - 1;
      default: return int'($urandom_range(0, lim - 1));
    endcase
  endfunction

  initial begin
    int g;
    for (int a = 0; a < MAP_W * MAP_H; a++) rom_mem[a] = 2'b00;
    #2 Reset = 1'b1;
    repeat (3) tick();
    check("reset_ack", int'(ack), 0);
    check("reset_walls", int'(walls_out), 0);
    check("reset_rd", int'(rom_rd), 0);
    check("reset_addr", int'(rom_addr), 0);

    // All five requesters at once: served 0..4, one grant period apart.
    auto_drop = 1'b1;
    clear_log();
    for (int i = 0; i < N_REQ; i++) set_xy(i, 3 + 7 * i, 2 + 5 * i);
    Reset = 1'b0;
    req = '1;
    g = n + 1;
    wait_acks(N_REQ, N_REQ * PERIOD + 20);
    if (ack_cyc_log.size() == N_REQ) begin
      check("t3_latency", ack_cyc_log[0] - g, LAT);
      for (int i = 0; i < N_REQ; i++) begin
        check("t3_order", ack_idx_log[i], i);
        if (i > 0) check("t3_spacing", ack_cyc_log[i] - ack_cyc_log[i-1], PERIOD);
      end
    end

    // Walls above and left of (5,5); coordinates changed after grant must be ignored.
    rom_mem[4 * MAP_W + 5] = WALL;
    rom_mem[5 * MAP_W + 4] = WALL;
    run_single("t1", 0, 5, 5, 4'b1001, 4, 1'b1);
    // Corner tile: up and left forced, only right and down read.
    run_single("t2", 2, 0, 0, 4'b1001, 2, 1'b0);

    // Pointer now after 2: requester 3 beats requester 1.
    clear_log();
    set_xy(1, 0, 0);
    set_xy(3, 20, 20);
    req[1] = 1'b1;
    req[3] = 1'b1;
    wait_acks(2, 2 * PERIOD + 10);
    if (ack_idx_log.size() == 2) begin
      check("t4_first", ack_idx_log[0], 3);
      check("t4_second", ack_idx_log[1], 1);
    end
    check("t4_walls", int'(walls_out), 4'b1001);

    // Reset in slot 2 of a lookup: outputs clear at once, no ack, pointer back to 0.
    clear_log();
    set_xy(3, 10, 10);
    req[3] = 1'b1;
    g = n + 1;
    while (n < g + 2 * SLOT) tick();
    #1;
    check("t5_slot2_rd", int'(rom_rd), 1);
    Reset = 1'b1;
    #1;
    check("t5_rst_ack", int'(ack), 0);
    check("t5_rst_rd", int'(rom_rd), 0);
    check("t5_rst_walls", int'(walls_out), 0);
    req[3] = 1'b0;
    set_xy(4, 39, 29);
    set_xy(1, 7, 8);
    req[4] = 1'b1;
    req[1] = 1'b1;
    repeat (3) tick();
    check("t5_no_ack", ack_idx_log.size(), 0);
    clear_log();
    Reset = 1'b0;
    wait_acks(2, 2 * PERIOD + 10);
    if (ack_idx_log.size() == 2) begin
      check("t5_first", ack_idx_log[0], 1);
      check("t5_second", ack_idx_log[1], 4);
    end
    check("t5_walls", int'(walls_out), 4'b0110);

    // Randomized traffic over a random maze.
    for (int a = 0; a < MAP_W * MAP_H; a++) rom_mem[a] = 2'($urandom_range(0, 3));
    auto_drop = 1'b0;
    repeat (3000) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          if (ack_prev[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            else set_xy(i, rand_coord(MAP_W), rand_coord(MAP_H));
          end else if ($urandom_range(0, 99) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          set_xy(i, rand_coord(MAP_W), rand_coord(MAP_H));
          req[i] = 1'b1;
        end
      end
    end
    auto_drop = 1'b1;
    repeat (N_REQ * PERIOD + 20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
